booth_mul_seq: RTL

Iterative signed 32×32 multiplier front-end for the Mini-SRC MUL instruction. It sits directly upstream of `reducer_64`. Each cycle it generates two radix-4 Booth partial products and presents them, together with its registered running sum/carry, as the four reducer operands. It registers the reducer's outputs back, and after all 16 partial products it resolves sum+carry into the 64-bit HI/LO result.

---
 rtl/booth_mul_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative signed 32x32 radix-4 Booth multiplier
// front-end feeding an external 4:2 reducer, two digits per cycle.
module booth_mul_seq (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic        in_start,
  input  logic [31:0] in_multiplicand,
  input  logic [31:0] in_multiplier,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic [63:0] out_red_w,
  output logic [63:0] out_red_x,
  output logic [63:0] out_red_y,
  output logic [63:0] out_red_z,
  output logic        out_red_cin,
  input  logic [63:0] in_red_sum,
  input  logic [63:0] in_red_carry
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ADD
  } state_t;

  state_t      state;
  logic [2:0]  k;
  logic [31:0] m_q;
  logic [31:0] q_q;
  logic [63:0] acc_sum;
  logic [63:0] acc_carry;

  function automatic logic [63:0] booth_pp(
    input logic [31:0] m,
    input logic [31:0] q,
    input logic [3:0]  j
  );
    logic [32:0] qx;
    logic [4:0]  sh;
    logic [2:0]  trip;
    logic [63:0] m64;
    logic [63:0] val;
    qx   = {q, 1'b0};
    sh   = {j, 1'b0};
    trip = qx[sh +: 3];
    m64  = {{32{m[31]}}, m};
    unique case (1'b1)
      (trip == 3'b011):
        val = m64 << 1;
      (trip == 3'b100):
        val = -(m64 << 1);
      (trip == 3'b001 || trip == 3'b010):
        val = m64;
      (trip == 3'b101 || trip == 3'b110):
        val = -m64;
      default:
        val = '0;
    endcase
    return val << sh;
  endfunction

  assign out_busy    = (state != IDLE);
  assign out_red_cin = 1'b0;

  // Reducer operands: running sum/carry plus two Booth terms.
  always_comb begin
    out_red_w = '0;
    out_red_x = '0;
    out_red_y = '0;
    out_red_z = '0;
    if (state == ACCUM) begin
      out_red_w = acc_sum;
      out_red_x = acc_carry;
      out_red_y = booth_pp(m_q, q_q, {k, 1'b0});
      out_red_z = booth_pp(m_q, q_q, {k, 1'b1});
    end
  end

  // Control FSM with accumulator and result registers.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= IDLE;
      k         <= '0;
      m_q       <= '0;
      q_q       <= '0;
      acc_sum   <= '0;
      acc_carry <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_done  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_start) begin
            m_q       <= in_multiplicand;
            q_q       <= in_multiplier;
            acc_sum   <= '0;
            acc_carry <= '0;
            k         <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          acc_sum   <= in_red_sum;
          acc_carry <= in_red_carry;
          k         <= k + 3'd1;
          if (k == 3'd7)
            state <= ADD;
        end
        ADD: begin
          {out_hi, out_lo} <= acc_sum + acc_carry;
          out_done         <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
